// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
//
// Purpose:
//   Multi-cycle sequencer for unsigned multiply and divide. It reuses the
//   shared combinational ALU and performs one iteration per clock. It never
//   contains an adder of its own: every add or subtract goes through
//   alu_A/alu_B/alu_op, and the sequencer reads back alu_result and
//   alu_carryout. The core issues one request and then stalls until the
//   response handshake.
//
//   Multiply uses unsigned shift-add:
//     HI/LO form the running product, and M is the multiplicand.
//   Divide uses unsigned restoring division:
//     R is the remainder, Q is the quotient/dividend, and D is the divisor.
//   The two algorithms use the same three data registers:
//     accHi_q  = HI or R
//     accLo_q  = LO or Q
//     operand_q = M or D
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake (req_ready = state is IDLE)
//   req_op              00 MULU, 01 MULHU, 10 DIVU, 11 REMU
//   req_a, req_b        multiplicand/dividend, multiplier/divisor
//   resp_valid/ready    response handshake; resp_data holds while waiting
//   resp_data           selected result word
//   busy                high while running or holding a result
//   alu_A, alu_B        ALU operands (0 outside RUN)
//   alu_op              ALU opcode: 010 ADD, 110 SUB (ADD outside RUN)
//   alu_result          ALU result
//   alu_carryout        ALU carry (ADD) / borrow (SUB, 1 when A < B)
// ---------------------------------------------------------------------------
module alu_muldiv_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [2:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_carryout
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [1:0]              op_q, op_d;
    logic [DATA_WIDTH-1:0]   accHi_q, accHi_d;
    logic [DATA_WIDTH-1:0]   accLo_q, accLo_d;
    logic [DATA_WIDTH-1:0]   operand_q, operand_d;

    logic                    isDiv;
    logic                    divTop;
    logic [DATA_WIDTH-1:0]   divPartial;
    logic                    quotBit;

    // op_q[1] separates the divide ops from the multiply ops.
    // divPartial is the remainder shifted left by one, with the next
    // dividend bit moved in at the bottom. divTop is the bit shifted out
    // at the top. When divTop is set, the true partial remainder is wider
    // than DATA_WIDTH, so it is certainly >= D. A borrow from the ALU
    // must then be ignored.
    assign isDiv      = op_q[1];
    assign divTop     = accHi_q[DATA_WIDTH-1];
    assign divPartial = {accHi_q[DATA_WIDTH-2:0], accLo_q[DATA_WIDTH-1]};

    // Handshake and status outputs come straight from the state.
    // resp_data is forced to zero outside DONE.
    // op_q[0] selects the high or remainder word:
    //   MULHU -> HI
    //   REMU  -> R
    // The other two ops return the low or quotient word.
    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == DONE);
    assign resp_data  = (state_q == DONE) ? (op_q[0] ? accHi_q : accLo_q)
                                          : '0;

    // ALU drive is purely combinational from the state and registers, so
    // the result comes back within the same cycle.
    // Outside RUN the ALU sees a harmless ADD of zeros, leaving it free
    // for other users.
    always_comb begin
        alu_A  = '0;
        alu_B  = '0;
        alu_op = ALU_ADD;
        if (state_q == RUN) begin
            if (isDiv) begin
                alu_op = ALU_SUB;
                alu_A  = divPartial;
                alu_B  = operand_q;
            end else begin
                alu_op = ALU_ADD;
                alu_A  = accHi_q;
                alu_B  = accLo_q[0] ? operand_q : '0;
            end
        end
    end

    // Next-state logic and datapath updates. Each RUN cycle retires one
    // bit.
    //
    // Multiply: the 33-bit sum {carry, result} is the new high half,
    // shifted right by one. Its low bit moves into the top of LO, which
    // shifts right as well, so the next multiplier bit reaches LO[0].
    //
    // Divide: keep the difference when P >= D. Otherwise restore P.
    // Then shift the quotient bit into Q.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        accHi_d   = accHi_q;
        accLo_d   = accLo_q;
        operand_d = operand_q;
        quotBit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d   = RUN;
                    count_d   = '0;
                    op_d      = req_op;
                    accHi_d   = '0;
                    accLo_d   = req_op[1] ? req_a : req_b;
                    operand_d = req_op[1] ? req_b : req_a;
                end
            end

            RUN: begin
                if (isDiv) begin
                    quotBit = divTop | ~alu_carryout;
                    accHi_d = quotBit ? alu_result : divPartial;
                    accLo_d = {accLo_q[DATA_WIDTH-2:0], quotBit};
                end else begin
                    accHi_d = {alu_carryout, alu_result[DATA_WIDTH-1:1]};
                    accLo_d = {alu_result[0], accLo_q[DATA_WIDTH-1:1]};
                end
                count_d = count_q + 1'b1;
                if (count_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    // Reset discards any operation that is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            op_q      <= 2'b00;
            accHi_q   <= '0;
            accLo_q   <= '0;
            operand_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            accHi_q   <= accHi_d;
            accLo_q   <= accLo_d;
            operand_q <= operand_d;
        end
    end

endmodule
